uart_rx: RTL and testbench

//  8N1 UART receiver: the receive-side partner of uart_tx on the ONC-16 memory-mapped I/O.

---
 rtl/uart_rx_pkg.sv | 24 ++
 rtl/uart_rx_if.sv | 23 ++
 rtl/uart_rx_sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 140 ++++++++++++++
 tb/tb_uart_rx.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receiver: memory-map addresses, status bit positions,
// FSM state encoding and the default bit period.
package uart_rx_pkg;

    localparam int unsigned DEF_CLKS_PER_BIT = 434;

    localparam logic [11:0] UART_STATUS    = 12'h800;
    localparam logic [11:0] UART_DATA      = 12'h801;
    localparam logic [11:0] UART_RX_STATUS = 12'h802;
    localparam logic [11:0] UART_RX_DATA   = 12'h803;

    localparam int unsigned STAT_FULL_BIT  = 0;
    localparam int unsigned STAT_OVR_BIT   = 1;
    localparam int unsigned STAT_FERR_BIT  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// CPU/pin-side signal bundle of the UART receiver; slave is the receiver, master drives it.
interface uart_rx_if;

    logic       rx;
    logic       rd_ack;
    logic       clr_err;
    logic [7:0] rx_data;
    logic       rx_full;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;

    modport master (
        output rx, rd_ack, clr_err,
        input  rx_data, rx_full, rx_valid, overrun, frame_err
    );

    modport slave (
        input  rx, rd_ack, clr_err,
        output rx_data, rx_full, rx_valid, overrun, frame_err
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
    parameter int unsigned     WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clock,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clock) begin
        if (!n_rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a one-entry read buffer with
// sticky overrun and framing-error flags.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       n_rst,
    uart_rx_if.slave   bus
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_s;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_full_q, rx_full_d;
    logic             rx_valid_q, rx_valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic             good_stop, bad_stop;

    sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
        .clock (clock),
        .n_rst (n_rst),
        .d     (bus.rx),
        .q     (rx_s)
    );

    always_ff @(posedge clock) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_full_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_full_q   <= rx_full_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Frame sequencing: half-bit wait validates the start bit, then full-bit steps land mid-bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        good_stop = 1'b0;
        bad_stop  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[7:1]};
                    if (idx_q == 3'd7) state_d = ST_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    good_stop = rx_s;
                    bad_stop  = !rx_s;
                    state_d   = rx_s ? ST_IDLE : ST_BREAK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read buffer and sticky flags; a flag being set outranks a same-cycle clear.
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_full_d   = rx_full_q;
        rx_valid_d  = good_stop;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (bus.clr_err) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (bus.rd_ack) rx_full_d = 1'b0;
        if (good_stop) begin
            if (!rx_full_q || bus.rd_ack) begin
                rx_data_d = shreg_q;
                rx_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (bad_stop) frame_err_d = 1'b1;
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_full   = rx_full_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=8: bit-accurate serial driver, hand-computed
// expectations checked with immediate assertions.
module tb_uart_rx;

    localparam int unsigned CPB = 8;

    logic clock = 1'b0;
    logic n_rst;
    int   errors = 0;
    int   checks = 0;
    int   valid_cnt = 0;
    int   exp_valid = 0;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clock (clock),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.rx_valid === 1'b1) valid_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One 8N1 frame, LSB first; the line is left at the stop-bit level.
    task automatic send_byte(input logic [7:0] data, input logic stop_bit);
        bus.rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rx = data[i];
            cycles(CPB);
        end
        bus.rx = stop_bit;
        cycles(CPB);
    endtask

    task automatic pulse_rd_ack();
        bus.rd_ack = 1'b1;
        cycles(1);
        bus.rd_ack = 1'b0;
    endtask

    task automatic pulse_clr_err();
        bus.clr_err = 1'b1;
        cycles(1);
        bus.clr_err = 1'b0;
    endtask

    initial begin
        n_rst       = 1'b0;
        bus.rx      = 1'b1;
        bus.rd_ack  = 1'b0;
        bus.clr_err = 1'b0;
        cycles(4);
        check("reset rx_data",   32'(bus.rx_data),   32'h0);
        check("reset rx_full",   32'(bus.rx_full),   32'h0);
        check("reset rx_valid",  32'(bus.rx_valid),  32'h0);
        check("reset overrun",   32'(bus.overrun),   32'h0);
        check("reset frame_err", 32'(bus.frame_err), 32'h0);
        n_rst = 1'b1;
        cycles(4);

        // 1: clean frame
        send_byte(8'h55, 1'b1);
        cycles(4);
        exp_valid += 1;
        check("t1 valid pulses", 32'(valid_cnt),     32'(exp_valid));
        check("t1 rx_data",      32'(bus.rx_data),   32'h55);
        check("t1 rx_full",      32'(bus.rx_full),   32'h1);
        check("t1 overrun",      32'(bus.overrun),   32'h0);
        check("t1 frame_err",    32'(bus.frame_err), 32'h0);
        pulse_rd_ack();
        check("t1 rd_ack clears full", 32'(bus.rx_full), 32'h0);
        pulse_rd_ack();
        check("t1 rd_ack when empty",  32'(bus.rx_data), 32'h55);

        // 2: short glitch is rejected
        bus.rx = 1'b0;
        cycles(3);
        bus.rx = 1'b1;
        cycles(20);
        check("t2 no valid",     32'(valid_cnt),     32'(exp_valid));
        check("t2 rx_full",      32'(bus.rx_full),   32'h0);
        check("t2 frame_err",    32'(bus.frame_err), 32'h0);

        // 3: back-to-back frames without reading
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        cycles(4);
        exp_valid += 2;
        check("t3 valid pulses", 32'(valid_cnt),     32'(exp_valid));
        check("t3 rx_data",      32'(bus.rx_data),   32'hA5);
        check("t3 rx_full",      32'(bus.rx_full),   32'h1);
        check("t3 overrun",      32'(bus.overrun),   32'h1);
        pulse_clr_err();
        check("t3 clr overrun",  32'(bus.overrun),   32'h0);
        check("t3 full kept",    32'(bus.rx_full),   32'h1);
        pulse_rd_ack();

        // 4: framing error followed by a held-low line
        send_byte(8'h7E, 1'b0);
        cycles(16);
        check("t4 frame_err",    32'(bus.frame_err), 32'h1);
        check("t4 rx_full",      32'(bus.rx_full),   32'h0);
        pulse_clr_err();
        cycles(99);
        check("t4 single ferr",  32'(bus.frame_err), 32'h0);
        check("t4 no valid",     32'(valid_cnt),     32'(exp_valid));
        bus.rx = 1'b1;
        cycles(4);
        send_byte(8'h12, 1'b1);
        cycles(4);
        exp_valid += 1;
        check("t4 rx_data",      32'(bus.rx_data),   32'h12);
        check("t4 rx_full",      32'(bus.rx_full),   32'h1);

        // 5: rd_ack lands in the stop-sample cycle (78 negedges after the start edge)
        fork
            send_byte(8'h99, 1'b1);
            begin
                cycles(78);
                bus.rd_ack = 1'b1;
                cycles(1);
                check("t5 valid on ack", 32'(bus.rx_valid), 32'h1);
                bus.rd_ack = 1'b0;
            end
        join
        cycles(4);
        exp_valid += 1;
        check("t5 rx_data",      32'(bus.rx_data),   32'h99);
        check("t5 rx_full",      32'(bus.rx_full),   32'h1);
        check("t5 overrun",      32'(bus.overrun),   32'h0);

        // 6: reset during data bit 4 abandons the frame
        fork
            send_byte(8'hF0, 1'b1);
            begin
                cycles(44);
                n_rst = 1'b0;
                cycles(1);
                n_rst = 1'b1;
            end
        join
        cycles(4);
        check("t6 rx_data",      32'(bus.rx_data),   32'h0);
        check("t6 rx_full",      32'(bus.rx_full),   32'h0);
        check("t6 overrun",      32'(bus.overrun),   32'h0);
        check("t6 frame_err",    32'(bus.frame_err), 32'h0);
        check("t6 no valid",     32'(valid_cnt),     32'(exp_valid));
        send_byte(8'hC3, 1'b1);
        cycles(4);
        check("t6 rx_data C3",   32'(bus.rx_data),   32'hC3);
        check("t6 rx_full",      32'(bus.rx_full),   32'h1);
        pulse_rd_ack();
        send_byte(8'h41, 1'b1);
        cycles(4);
        check("t6 loopback 41",  32'(bus.rx_data),   32'h41);
        check("t6 overrun end",  32'(bus.overrun),   32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
